// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared cache types. Holds the miss/refill sequencer state
//                encoding and the default-geometry line-address type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Miss/refill sequencer states, one miss in flight at a time.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VICTIM  = 3'd1,
        WB_REQ  = 3'd2,
        WB_DATA = 3'd3,
        RF_REQ  = 3'd4,
        RF_DATA = 3'd5,
        INSTALL = 3'd6
    } refill_state_t;

    // Default cache geometry.
    localparam int unsigned c_DEFAULT_INDEX_WIDTH = 5;
    localparam int unsigned c_DEFAULT_TAG_WIDTH   = 20;

    // Memory line address {tag, index} at the default geometry.
    typedef logic [c_DEFAULT_TAG_WIDTH+c_DEFAULT_INDEX_WIDTH-1:0] line_addr_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/miss_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : miss_refill_ctrl
//  Description : Sequences one cache-line miss. It asks the replacement unit
//                for a victim way and writes that line back if it is dirty.
//                It then refills the line from memory and installs the new
//                tag.
//  Ports       : clk/rst          - clock, synchronous active-high reset
//                halt             - blocks acceptance of new misses only
//                miss_*           - miss handshake from the lookup stage
//                repl_*           - replacement unit drive / victim way
//                victim_*         - victim tag and valid&dirty (comb lookup)
//                mem_req_*        - line request (writeback or refill)
//                mem_w* / mem_r*  - writeback beats out, refill beats in
//                arr_*, fill_we   - data array way/word pointer and fill write
//                tag_we/tag_wdata - tag install
//                done             - one-cycle pulse when the line is installed
//  Revision    : 1.0 - initial release
// ============================================================================
module miss_refill_ctrl
    import cache_pkg::*;
#(
    parameter  int unsigned INDEX_WIDTH = 5,
    parameter  int unsigned SET_SIZE    = 2,
    parameter  int unsigned TAG_WIDTH   = 20,
    parameter  int unsigned LINE_WORDS  = 4,
    parameter  int unsigned DATA_WIDTH  = 32,
    localparam int unsigned WORD_BITS   = $clog2(LINE_WORDS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           halt,
    // lookup stage
    input  logic                           miss_valid,
    input  logic [INDEX_WIDTH-1:0]         miss_index,
    input  logic [TAG_WIDTH-1:0]           miss_tag,
    output logic                           miss_ready,
    // replacement unit
    output logic                           repl_valid,
    output logic [INDEX_WIDTH-1:0]         repl_index,
    output logic                           repl_miss,
    input  logic [SET_SIZE-1:0]            repl_evict_way,
    input  logic [TAG_WIDTH-1:0]           victim_tag,
    input  logic                           victim_dirty,
    // memory port
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_write,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_req_line,
    output logic                           mem_wvalid,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_rvalid,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    // data / tag arrays
    output logic [SET_SIZE-1:0]            arr_way,
    output logic [WORD_BITS-1:0]           arr_word,
    input  logic [DATA_WIDTH-1:0]          arr_rdata,
    output logic                           fill_we,
    output logic                           tag_we,
    output logic [TAG_WIDTH-1:0]           tag_wdata,
    output logic                           done
);

    localparam logic [WORD_BITS-1:0] c_LAST_WORD = WORD_BITS'(LINE_WORDS - 1);
    localparam logic [WORD_BITS-1:0] c_WORD_ONE  = WORD_BITS'(1);

    refill_state_t          r_state;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [SET_SIZE-1:0]    r_way;
    logic [TAG_WIDTH-1:0]   r_vtag;
    // Shared by writeback and refill. It always returns to 0 on leaving
    // either data phase, so each phase starts at word 0.
    logic [WORD_BITS-1:0]   r_word;

    logic w_last_word;
    assign w_last_word = (r_word == c_LAST_WORD);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_index <= '0;
            r_tag   <= '0;
            r_way   <= '0;
            r_vtag  <= '0;
            r_word  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (miss_valid && !halt) begin
                        r_index <= miss_index;
                        r_tag   <= miss_tag;
                        r_state <= VICTIM;
                    end
                end
                VICTIM: begin
                    // The dirty flag only steers this transition. It is not
                    // needed later, so it is consumed here and not stored.
                    r_way   <= repl_evict_way;
                    r_vtag  <= victim_tag;
                    r_word  <= '0;
                    r_state <= victim_dirty ? WB_REQ : RF_REQ;
                end
                WB_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    // Memory never stalls writeback beats: one word per cycle.
                    r_word <= r_word + c_WORD_ONE;
                    if (w_last_word) begin
                        r_word  <= '0;
                        r_state <= RF_REQ;
                    end
                end
                RF_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= RF_DATA;
                    end
                end
                RF_DATA: begin
                    // Gaps in mem_rvalid leave the pointer where it is.
                    if (mem_rvalid) begin
                        r_word <= r_word + c_WORD_ONE;
                        if (w_last_word) begin
                            r_word  <= '0;
                            r_state <= INSTALL;
                        end
                    end
                end
                INSTALL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the registered state. While rst is high every
    // output is forced quiet. A reset that lands mid-miss therefore cannot
    // issue one last memory request or array write in its own cycle.
    // ------------------------------------------------------------------------
    logic w_run;
    assign w_run = !rst;

    assign miss_ready = !halt && (rst || (r_state == IDLE));

    always_comb begin
        repl_valid    = 1'b0;
        repl_index    = '0;
        repl_miss     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_line  = '0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        arr_way       = '0;
        arr_word      = '0;
        fill_we       = 1'b0;
        tag_we        = 1'b0;
        tag_wdata     = '0;
        done          = 1'b0;
        if (w_run) begin
            arr_way   = r_way;
            arr_word  = r_word;
            tag_wdata = r_tag;
            unique case (r_state)
                VICTIM: begin
                    repl_valid = 1'b1;
                    repl_miss  = 1'b1;
                    repl_index = r_index;
                end
                WB_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_write = 1'b1;
                    mem_req_line  = {r_vtag, r_index};
                end
                WB_DATA: begin
                    mem_wvalid = 1'b1;
                    mem_wdata  = arr_rdata;
                end
                RF_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_line  = {r_tag, r_index};
                end
                RF_DATA: begin
                    fill_we = mem_rvalid;
                end
                INSTALL: begin
                    tag_we = 1'b1;
                    done   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : miss_refill_ctrl
`default_nettype wire

// File: tb/tb_miss_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miss_refill_ctrl
//  Description : Directed self-checking bench for miss_refill_ctrl. Plays the
//                lookup stage, the replacement unit, the memory and the data
//                array. All expected values are hand-derived.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_miss_refill_ctrl;

    localparam int unsigned c_IW = 5;
    localparam int unsigned c_SS = 2;
    localparam int unsigned c_TW = 20;
    localparam int unsigned c_LW = 4;
    localparam int unsigned c_DW = 32;
    localparam int unsigned c_WB = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 halt = 1'b0;
    logic                 miss_valid = 1'b0;
    logic [c_IW-1:0]      miss_index = '0;
    logic [c_TW-1:0]      miss_tag = '0;
    logic                 miss_ready;
    logic                 repl_valid;
    logic [c_IW-1:0]      repl_index;
    logic                 repl_miss;
    logic [c_SS-1:0]      repl_evict_way = '0;
    logic [c_TW-1:0]      victim_tag = '0;
    logic                 victim_dirty = 1'b0;
    logic                 mem_req_valid;
    logic                 mem_req_ready = 1'b0;
    logic                 mem_req_write;
    logic [c_TW+c_IW-1:0] mem_req_line;
    logic                 mem_wvalid;
    logic [c_DW-1:0]      mem_wdata;
    logic                 mem_rvalid = 1'b0;
    logic [c_DW-1:0]      mem_rdata = '0;
    logic [c_SS-1:0]      arr_way;
    logic [c_WB-1:0]      arr_word;
    logic [c_DW-1:0]      arr_rdata;
    logic                 fill_we;
    logic                 tag_we;
    logic [c_TW-1:0]      tag_wdata;
    logic                 done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Data array model: each word holds a value unique to its way and word.
    assign arr_rdata = 32'hA000_0000 | (32'(arr_way) << 8) | 32'(arr_word);

    miss_refill_ctrl #(
        .INDEX_WIDTH (c_IW),
        .SET_SIZE    (c_SS),
        .TAG_WIDTH   (c_TW),
        .LINE_WORDS  (c_LW),
        .DATA_WIDTH  (c_DW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .miss_valid     (miss_valid),
        .miss_index     (miss_index),
        .miss_tag       (miss_tag),
        .miss_ready     (miss_ready),
        .repl_valid     (repl_valid),
        .repl_index     (repl_index),
        .repl_miss      (repl_miss),
        .repl_evict_way (repl_evict_way),
        .victim_tag     (victim_tag),
        .victim_dirty   (victim_dirty),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_line   (mem_req_line),
        .mem_wvalid     (mem_wvalid),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .arr_way        (arr_way),
        .arr_word       (arr_word),
        .arr_rdata      (arr_rdata),
        .fill_we        (fill_we),
        .tag_we         (tag_we),
        .tag_wdata      (tag_wdata),
        .done           (done)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one miss from acceptance to done (or to a planted reset).
    // Called and returns at posedge+1.
    task automatic run_miss(
        input  logic [c_IW-1:0] idx,
        input  logic [c_TW-1:0] tag,
        input  logic [c_SS-1:0] way,
        input  logic [c_TW-1:0] vtag,
        input  logic            dirty,
        input  int              rdy_delay,
        input  logic [7:0]      gap_pat,
        input  bit              halt_mid,
        input  int              rst_after,
        input  bit              hold_valid,
        output int              acc,
        output int              lat
    );
        int cyc;
        int n_fill;
        int n_wb;
        int wait_cnt;
        int gp;
        int nrepl;
        bit rf;
        bit fin;
        bit held;
        logic [c_TW+c_IW-1:0] held_line;
        logic held_w;
        cyc = 0; n_fill = 0; n_wb = 0; wait_cnt = 0; gp = 0; nrepl = 0;
        rf = 0; fin = 0; held = 0; held_line = '0; held_w = 1'b0;
        acc = -1; lat = -1;
        repl_evict_way = way;
        victim_tag     = vtag;
        victim_dirty   = dirty;
        miss_index     = idx;
        miss_tag       = tag;
        miss_valid     = 1'b1;
        while (!fin && cyc < 60) begin
            // drive this cycle's memory inputs
            mem_req_ready = mem_req_valid && (wait_cnt >= rdy_delay);
            mem_rvalid    = 1'b0;
            if (rf && n_fill < 4) begin
                mem_rvalid = gap_pat[gp % 8];
                mem_rdata  = 32'hC0DE_0000 + 32'(n_fill);
                gp++;
                if (halt_mid) halt = 1'b1;
                if (rst_after > 0 && n_fill == rst_after) begin
                    rst        = 1'b1;
                    mem_rvalid = 1'b1;
                end
            end
            @(negedge clk);
            if (miss_valid && miss_ready && acc < 0) acc = cyc;
            if (repl_miss) begin
                nrepl++;
                check_val("repl_cycle", 64'(cyc), 64'(acc + 1));
                check_val("repl_index", 64'(repl_index), 64'(idx));
                check_val("repl_valid", 64'(repl_valid), 64'd1);
            end
            if (held) begin
                check_val("req_hold_valid", 64'(mem_req_valid), 64'd1);
                check_val("req_hold_line", 64'(mem_req_line), 64'(held_line));
                check_val("req_hold_write", 64'(mem_req_write), 64'(held_w));
            end
            held = 0;
            if (mem_req_valid) begin
                if (mem_req_ready) begin
                    wait_cnt = 0;
                    if (mem_req_write) begin
                        check_val("wb_req_line", 64'(mem_req_line), 64'({vtag, idx}));
                    end else begin
                        check_val("rf_req_line", 64'(mem_req_line), 64'({tag, idx}));
                        rf = 1;
                    end
                end else begin
                    wait_cnt++;
                    held      = 1;
                    held_line = mem_req_line;
                    held_w    = mem_req_write;
                end
            end
            if (mem_wvalid) begin
                check_val("wb_word", 64'(arr_word), 64'(n_wb));
                check_val("wb_way", 64'(arr_way), 64'(way));
                check_val("wb_data", 64'(mem_wdata),
                          64'(32'hA000_0000 | (32'(way) << 8) | 32'(n_wb)));
                n_wb++;
            end
            if (rst) begin
                check_val("rst_fill_we", 64'(fill_we), 64'd0);
                check_val("rst_tag_we", 64'(tag_we), 64'd0);
                check_val("rst_done", 64'(done), 64'd0);
                check_val("rst_req_valid", 64'(mem_req_valid), 64'd0);
                fin = 1;
            end else if (rf && n_fill < 4 && !mem_req_valid) begin
                check_val("fill_we", 64'(fill_we), 64'(mem_rvalid));
                check_val("fill_word", 64'(arr_word), 64'(n_fill));
                if (mem_rvalid) begin
                    check_val("fill_way", 64'(arr_way), 64'(way));
                    n_fill++;
                end
            end
            if (done) begin
                check_val("done_tag_we", 64'(tag_we), 64'd1);
                check_val("done_tag_wdata", 64'(tag_wdata), 64'(tag));
                check_val("done_fills", 64'(n_fill), 64'd4);
                check_val("done_fill_we", 64'(fill_we), 64'd0);
                lat = cyc - acc;
                fin = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc >= 0 && !hold_valid) miss_valid = 1'b0;
        end
        rst           = 1'b0;
        halt          = 1'b0;
        mem_rvalid    = 1'b0;
        mem_req_ready = 1'b0;
        check_val("repl_pulses", 64'(nrepl), 64'd1);
        check_val("wb_beats", 64'(rst_after > 0 ? 0 : n_wb), 64'(rst_after > 0 ? 0 : (dirty ? 4 : 0)));
        if (!fin) check_val("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int lat;
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_miss_ready", 64'(miss_ready), 64'd1);
        check_val("rst_repl_valid", 64'(repl_valid), 64'd0);
        check_val("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_arr_word", 64'(arr_word), 64'd0);
        halt = 1'b1;
        #1;
        check_val("rst_halt_ready", 64'(miss_ready), 64'd0);
        halt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- clean miss ----------------
        run_miss(5'd5, 20'h01234, 2'd2, 20'h00000, 1'b0, 0, 8'hFF, 0, 0, 0, acc, lat);
        check_val("clean_latency", 64'(lat), 64'd7);

        // ---------------- dirty miss ----------------
        run_miss(5'd5, 20'h01234, 2'd2, 20'h0ABCD, 1'b1, 0, 8'hFF, 0, 0, 0, acc, lat);
        check_val("dirty_latency", 64'(lat), 64'd12);

        // ---------------- backpressure + rvalid gaps 1,0,0,1,1,0,1 ----------------
        run_miss(5'd17, 20'hBEEF1, 2'd1, 20'h55555, 1'b1, 3, 8'h59, 0, 0, 0, acc, lat);
        check_val("bp_latency", 64'(lat), 64'd21);

        // ---------------- halt in IDLE ----------------
        halt       = 1'b1;
        miss_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("halt_miss_ready", 64'(miss_ready), 64'd0);
            check_val("halt_repl_miss", 64'(repl_miss), 64'd0);
            @(posedge clk); #1;
        end
        miss_valid = 1'b0;
        halt       = 1'b0;

        // ---------------- halt raised mid-refill ----------------
        run_miss(5'd3, 20'h00777, 2'd3, 20'h00000, 1'b0, 0, 8'hFF, 1, 0, 0, acc, lat);
        check_val("halt_mid_latency", 64'(lat), 64'd7);

        // ---------------- reset during refill after 2 beats ----------------
        run_miss(5'd9, 20'h0F0F0, 2'd0, 20'h00000, 1'b0, 0, 8'hFF, 0, 2, 0, acc, lat);
        @(negedge clk);
        check_val("post_rst_ready", 64'(miss_ready), 64'd1);
        check_val("post_rst_done", 64'(done), 64'd0);
        check_val("post_rst_req", 64'(mem_req_valid), 64'd0);
        check_val("post_rst_word", 64'(arr_word), 64'd0);
        @(posedge clk); #1;
        run_miss(5'd9, 20'h0F0F0, 2'd1, 20'h00000, 1'b0, 0, 8'hFF, 0, 0, 0, acc, lat);
        check_val("post_rst_latency", 64'(lat), 64'd7);

        // ---------------- back-to-back with miss_valid held ----------------
        run_miss(5'd30, 20'h11111, 2'd2, 20'h00000, 1'b0, 0, 8'hFF, 0, 0, 1, acc, lat);
        check_val("b2b_first_latency", 64'(lat), 64'd7);
        run_miss(5'd30, 20'h11111, 2'd2, 20'h00000, 1'b0, 0, 8'hFF, 0, 0, 0, acc, lat);
        check_val("b2b_second_accept", 64'(acc), 64'd0);
        check_val("b2b_second_latency", 64'(lat), 64'd7);

        // ---------------- ignored inputs while idle ----------------
        mem_rvalid = 1'b1;
        @(negedge clk);
        check_val("idle_fill_we", 64'(fill_we), 64'd0);
        check_val("idle_ready", 64'(miss_ready), 64'd1);
        mem_rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_miss_refill_ctrl
`default_nettype wire
